uart_tx_fifo: RTL and testbench

Byte FIFO and dispatcher that sits directly upstream of the UART transmitter. It accepts bytes from the system side at up to one per clock and buffers them. It then hands them one at a time to the transmitter through a single-cycle data-valid strobe, and paces itself on the transmitter's active/done outputs. Back-to-back frames are therefore sent without host polling.

---
 rtl/uart_tx_fifo.sv | 108 ++++++++++
 tb/tb_uart_tx_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO plus dispatcher that launches bytes into the UART transmitter
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_dv,
  input  logic [7:0]            i_wr_data,
  input  logic                  i_ovf_clr,
  input  logic                  i_tx_active,
  input  logic                  i_tx_done,
  output logic                  o_tx_dv,
  output logic [7:0]            o_tx_byte,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ACT  = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  tx_dv_q, tx_dv_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  full, empty, push, pop;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  always_comb begin
    push      = i_wr_dv && !full;
    pop       = 1'b0;
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    case (state_q)
      // done is still high on the transmitter's first idle cycle, so it gates relaunch too
      S_IDLE: begin
        if (!empty && !i_tx_active && !i_tx_done) begin
          pop       = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = mem_q[rd_ptr_q];
          state_d   = S_WAIT_ACT;
        end
      end
      S_WAIT_ACT:  if (i_tx_active) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (i_tx_done)   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;

    ovf_d = (ovf_q && !i_ovf_clr) || (i_wr_dv && full);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_tx_dv    = tx_dv_q;
  assign o_tx_byte  = tx_byte_q;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_busy     = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a transmitter model and scoreboard
module tb_uart_tx_fifo;

  logic       clk, rst_n;
  logic       wr_dv, ovf_clr, tx_active, tx_done;
  logic [7:0] wr_data;
  logic       o_tx_dv, o_full, o_empty, o_overflow, o_busy;
  logic [7:0] o_tx_byte;
  logic [4:0] o_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tcnt  = -1;
  int n_launch = 0;
  bit hold  = 0;
  int sb_q[$];
  int st_q[$];

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_dv(wr_dv), .i_wr_data(wr_data),
    .i_ovf_clr(ovf_clr), .i_tx_active(tx_active), .i_tx_done(tx_done),
    .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte), .o_full(o_full), .o_empty(o_empty),
    .o_count(o_count), .o_overflow(o_overflow), .o_busy(o_busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (!o_busy && tcnt < 0 && !tx_done && !tx_active) begin
        ok = 1;
        break;
      end
      step();
    end
    chk(tag, ok, 1);
  endtask

  // Transmitter model: active 1 cycle after the strobe for 10 bit times, then done for 2 cycles.
  initial begin
    tx_active = 0;
    tx_done   = 0;
    forever begin
      @(negedge clk);
      if (tcnt < 0) begin
        tx_active = hold;
        if (o_tx_dv) begin
          n_launch++;
          st_q.push_back(cyc);
          if (sb_q.size() == 0) chk("launch_with_nothing_queued", o_tx_dv, 0);
          else chk("tx_byte_order", o_tx_byte, sb_q.pop_front());
          tcnt = 0;
        end
      end else begin
        chk("dv_while_tx_busy", o_tx_dv, 0);
        tcnt++;
        if (tcnt <= 10) tx_active = 1;
        else if (tcnt <= 12) begin
          tx_active = 0;
          tx_done   = 1;
        end else begin
          tx_done = 0;
          tcnt    = -1;
        end
      end
    end
  end

  initial begin
    int n0, k0, base;
    logic [7:0] b;
    rst_n = 0; wr_dv = 0; wr_data = 0; ovf_clr = 0;
    step(2);
    chk("rst_tx_dv", o_tx_dv, 0);
    chk("rst_tx_byte", o_tx_byte, 8'h00);
    chk("rst_full", o_full, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_count", o_count, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_busy", o_busy, 0);
    rst_n = 1;
    step(2);

    // single byte latency
    wr_dv = 1; wr_data = 8'hA5;
    step();
    sb_q.push_back(8'hA5);
    wr_dv = 0;
    chk("single_count_after_push", o_count, 1);
    chk("single_empty_after_push", o_empty, 0);
    chk("single_dv_too_early", o_tx_dv, 0);
    step();
    chk("single_dv", o_tx_dv, 1);
    chk("single_byte", o_tx_byte, 8'hA5);
    chk("single_count_after_pop", o_count, 0);
    step();
    chk("single_dv_one_cycle", o_tx_dv, 0);
    chk("single_byte_held", o_tx_byte, 8'hA5);
    wait_idle("single_idle_timeout");

    // burst of 3 with launch spacing
    k0 = st_q.size();
    for (int i = 1; i <= 3; i++) begin
      wr_dv = 1; wr_data = 8'(i);
      step();
      sb_q.push_back(i);
    end
    wr_dv = 0;
    wait_idle("burst_idle_timeout");
    chk("burst_launches", st_q.size() - k0, 3);
    if (st_q.size() - k0 == 3) begin
      chk("burst_gap1", st_q[k0+1] - st_q[k0], 14);
      chk("burst_gap2", st_q[k0+2] - st_q[k0+1], 14);
    end
    chk("burst_sb_drained", sb_q.size(), 0);

    // fill and overflow with the transmitter held busy
    hold = 1;
    step(3);
    n0 = n_launch;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      wr_dv = 1; wr_data = b;
      step();
      sb_q.push_back(b);
    end
    chk("fill_full", o_full, 1);
    chk("fill_count", o_count, 16);
    chk("fill_no_ovf_yet", o_overflow, 0);
    wr_data = 8'($urandom);
    step();
    wr_dv = 0;
    chk("ovf_set", o_overflow, 1);
    chk("ovf_count_unchanged", o_count, 16);
    wr_dv = 1; ovf_clr = 1;
    step();
    wr_dv = 0; ovf_clr = 0;
    chk("ovf_set_beats_clear", o_overflow, 1);
    ovf_clr = 1;
    step();
    ovf_clr = 0;
    chk("ovf_cleared", o_overflow, 0);
    hold = 0;
    wait_idle("fill_idle_timeout");
    chk("fill_launches", n_launch - n0, 16);
    chk("fill_sb_drained", sb_q.size(), 0);

    // simultaneous push and pop at count 1
    wr_dv = 1; wr_data = 8'h3C;
    step();
    sb_q.push_back(8'h3C);
    wr_data = 8'hC3;
    step();
    sb_q.push_back(8'hC3);
    wr_dv = 0;
    chk("simul_count", o_count, 1);
    chk("simul_dv", o_tx_dv, 1);
    chk("simul_first_byte", o_tx_byte, 8'h3C);
    wait_idle("simul_idle_timeout");
    chk("simul_sb_drained", sb_q.size(), 0);

    // wrap-around stream of 40 incrementing bytes at a sustainable random rate
    n0 = n_launch;
    base = $urandom_range(0, 255);
    for (int i = 0; i < 40; i++) begin
      wr_dv = 1; wr_data = 8'(base + i);
      step();
      sb_q.push_back((base + i) & 8'hFF);
      wr_dv = 0;
      step($urandom_range(9, 13));
    end
    chk("stream_no_ovf", o_overflow, 0);
    wait_idle("stream_idle_timeout");
    chk("stream_launches", n_launch - n0, 40);
    chk("stream_sb_drained", sb_q.size(), 0);

    // reset during a frame with bytes queued
    for (int i = 0; i < 6; i++) begin
      wr_dv = 1; wr_data = 8'($urandom);
      step();
      sb_q.push_back(wr_data);
    end
    wr_dv = 0;
    for (int i = 0; i < 100 && tcnt != 5; i++) step();
    chk("rstmid_reached_data_bits", tcnt, 5);
    rst_n = 0;
    #1;
    chk("rstmid_count", o_count, 0);
    chk("rstmid_empty", o_empty, 1);
    chk("rstmid_dv", o_tx_dv, 0);
    sb_q.delete();
    n0 = n_launch;
    step();
    rst_n = 1;
    wr_dv = 1; wr_data = 8'h5A;
    step();
    sb_q.push_back(8'h5A);
    wr_dv = 0;
    chk("rstmid_tx_still_busy", tx_active, 1);
    wait_idle("rstmid_idle_timeout");
    chk("rstmid_launches", n_launch - n0, 1);
    chk("rstmid_sb_drained", sb_q.size(), 0);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
